// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment scan driver.
//
// Segment vectors are declared [0:6] so that bit 0 is segment 'a' and the
// literals below read left-to-right as a..g. Segments are active-low:
// a 0 lights the segment.
//
// Contents:
//   seg_t       7-bit segment vector type, a..g
//   SEG_0..9    glyphs for the decimal digits
//   SEG_DASH    glyph shown for non-BCD nibbles 10..15
//   SEG_OFF     all segments dark
//   bcd_to_seg  nibble to glyph lookup
package seg7_pkg;

  typedef logic [0:6] seg_t;

  localparam seg_t SEG_0    = 7'b0000001;
  localparam seg_t SEG_1    = 7'b1001111;
  localparam seg_t SEG_2    = 7'b0010010;
  localparam seg_t SEG_3    = 7'b0000110;
  localparam seg_t SEG_4    = 7'b1001100;
  localparam seg_t SEG_5    = 7'b0100100;
  localparam seg_t SEG_6    = 7'b0100000;
  localparam seg_t SEG_7    = 7'b0001111;
  localparam seg_t SEG_8    = 7'b0000000;
  localparam seg_t SEG_9    = 7'b0000100;
  localparam seg_t SEG_DASH = 7'b1111110;
  localparam seg_t SEG_OFF  = 7'b1111111;

  // Anything outside 0..9 is not valid BCD and is shown as a dash so a
  // corrupted counter value is visible rather than silently misread.
  function automatic seg_t bcd_to_seg(input logic [3:0] bcd);
    seg_t s;
    case (bcd)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: bundle between the stopwatch logic and the display
// scan driver.
//
// Signals:
//   en         display enable (0 freezes scan and blanks the display)
//   load       one-cycle strobe capturing digits_in
//   digits_in  packed BCD, digit k at [4k+3:4k], digit 0 least significant
//   seg        segments a..g, seg[0]=a, active-low
//   an         one-hot anode enables (polarity set by the driver)
//   slot_idx   index of the digit currently addressed
//
// Modports:
//   master  the producer of BCD data (stopwatch side)
//   slave   the scan driver
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                en;
  logic                load;
  logic [4*DIGITS-1:0] digits_in;
  logic [0:6]          seg;
  logic [DIGITS-1:0]   an;
  logic [IDX_W-1:0]    slot_idx;

  modport master (
    output en, load, digits_in,
    input  seg, an, slot_idx
  );

  modport slave (
    input  en, load, digits_in,
    output seg, an, slot_idx
  );

endinterface

// File: rtl/seg7_encode.sv
// seg7_encode: combinational BCD nibble to seven-segment glyph lookup.
//
// Ports:
//   nibble  in   4  BCD value (10..15 render as a dash)
//   seg     out  7  segments a..g, seg[0]=a, active-low
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  always_comb begin
    seg = bcd_to_seg(nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for DIGITS common-anode
// seven-segment digits sharing one segment bus.
//
// A BCD word is captured into a shadow register on bus.load. The scan walks
// one digit per REFRESH_DIV-cycle slot; the first GUARD cycles of each slot
// keep every anode off so the previous digit's segments never ghost onto the
// next one. seg, an and slot_idx are all registered.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   bus    slave modport of seg7_scan_driver_if (en, load, digits_in in;
//          seg, an, slot_idx out)
//
// Parameters:
//   DIGITS         number of digits (1..8)
//   REFRESH_DIV    clk cycles per digit slot (>= GUARD+1)
//   GUARD          blank cycles at the start of each slot (0 = none)
//   AN_ACTIVE_LOW  1: enabled anode driven 0; 0: enabled anode driven 1
//
// Build option:
//   SEG7_LZ_BLANK_EN  when defined, leading zeros (digits above 0 whose
//                     nibble and all higher nibbles are zero) are blanked;
//                     their anode still fires so brightness stays uniform.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int GUARD         = 16,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  seg7_scan_driver_if.slave   bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);
  // Inactive anode pattern; XOR with a one-hot vector applies polarity.
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW != 0}};

  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow;
  logic [3:0]          nibble;
  seg_t                enc_seg;
  seg_t                digit_seg;
  logic [DIGITS-1:0]   an_onehot;
  logic                in_guard;
  logic                lz_blank;

  // Guard compare only exists when there is a guard, which avoids a
  // constant-false unsigned comparison for GUARD=0.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      localparam logic [DIV_W-1:0] GUARD_W = DIV_W'(GUARD);
      assign in_guard = (div_cnt < GUARD_W);
    end
  endgenerate

  assign nibble    = shadow[4*idx +: 4];
  assign an_onehot = AN_ONE << idx;

  seg7_encode u_encode (
    .nibble (nibble),
    .seg    (enc_seg)
  );

  // A digit is a leading zero when it and every nibble above it are zero;
  // shifting the shadow down by the digit position tests exactly that.
  // Digit 0 is excluded so a zero value still shows a single "0".
`ifdef SEG7_LZ_BLANK_EN
  assign lz_blank = (idx != '0) && ((shadow >> (4*idx)) == '0);
`else
  assign lz_blank = 1'b0;
`endif

  assign digit_seg = lz_blank ? SEG_OFF : enc_seg;

  // Shadow capture is independent of en so the display can be loaded while
  // blanked. The output stage reads the old shadow on a load edge, giving
  // a clean one-cycle latency and never a half-updated nibble.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
    end else if (bus.load) begin
      shadow <= bus.digits_in;
    end
  end

  // Slot timing: div_cnt paces each slot, idx selects the digit. Both
  // freeze while en is low so the scan resumes exactly where it stopped.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (bus.en) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Output registers are computed from the pre-edge counters, so each slot
  // appears one cycle after the counters enter it. slot_idx only moves when
  // a digit is actually driven and holds through guard and disable periods.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.seg      <= SEG_OFF;
      bus.an       <= AN_OFF;
      bus.slot_idx <= '0;
    end else if (!bus.en || in_guard) begin
      bus.seg <= SEG_OFF;
      bus.an  <= AN_OFF;
    end else begin
      bus.seg      <= digit_seg;
      bus.an       <= an_onehot ^ AN_OFF;
      bus.slot_idx <= idx;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed self-checking bench for seg7_scan_driver
// with DIGITS=4, REFRESH_DIV=4, GUARD=1, AN_ACTIVE_LOW=1. Each slot is one
// blank guard cycle followed by three lit cycles. Expected glyphs are
// written out here independently of the design package.
module tb_seg7_scan_driver;

  localparam int DIGITS        = 4;
  localparam int REFRESH_DIV   = 4;
  localparam int GUARD         = 1;
  localparam int AN_ACTIVE_LOW = 1;

  localparam logic [0:6] X0   = 7'b0000001;
  localparam logic [0:6] X1   = 7'b1001111;
  localparam logic [0:6] X2   = 7'b0010010;
  localparam logic [0:6] X3   = 7'b0000110;
  localparam logic [0:6] X4   = 7'b1001100;
  localparam logic [0:6] X5   = 7'b0100100;
  localparam logic [0:6] X6   = 7'b0100000;
  localparam logic [0:6] X7   = 7'b0001111;
  localparam logic [0:6] XDSH = 7'b1111110;
  localparam logic [0:6] XOFF = 7'b1111111;

  // A leading zero is dark with suppression built in, "0" otherwise.
`ifdef SEG7_LZ_BLANK_EN
  localparam logic [0:6] XLZ = XOFF;
`else
  localparam logic [0:6] XLZ = X0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   testCount = 0;
  int   failCount = 0;

  seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_driver #(
    .DIGITS        (DIGITS),
    .REFRESH_DIV   (REFRESH_DIV),
    .GUARD         (GUARD),
    .AN_ACTIVE_LOW (AN_ACTIVE_LOW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive inputs, take one edge, drop the load strobe.
  task automatic applyStimulus(input logic e, input logic ld, input logic [15:0] d);
    bus.en        = e;
    bus.load      = ld;
    bus.digits_in = d;
    cycle();
    bus.load = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [0:6] expSeg, input logic [3:0] expAn);
    testCount++;
    assert (bus.seg === expSeg) else begin
      failCount++;
      $error("[TB] FAIL %s seg got %b expected %b", tag, bus.seg, expSeg);
    end
    testCount++;
    assert (bus.an === expAn) else begin
      failCount++;
      $error("[TB] FAIL %s an got %b expected %b", tag, bus.an, expAn);
    end
  endtask

  task automatic checkIdx(input string tag, input logic [1:0] expIdx);
    testCount++;
    assert (bus.slot_idx === expIdx) else begin
      failCount++;
      $error("[TB] FAIL %s slot_idx got %0d expected %0d", tag, bus.slot_idx, expIdx);
    end
  endtask

  // One full slot: the guard edge (optionally carrying a load) then three
  // lit edges showing the expected digit.
  task automatic runSlot(input string tag, input logic ld, input logic [15:0] d,
                         input logic [0:6] expSeg, input logic [3:0] expAn,
                         input logic [1:0] expIdx);
    applyStimulus(1'b1, ld, d);
    checkOutput({tag, " guard"}, XOFF, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, d);
      checkOutput(tag, expSeg, expAn);
      checkIdx(tag, expIdx);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.en        = 1'b0;
    bus.load      = 1'b0;
    bus.digits_in = '0;
    cycle();
    cycle();
    checkOutput("reset", XOFF, 4'b1111);
    checkIdx("reset", 2'd0);
    reset = 1'b0;

    // Basic scan of 1234, digit 0 first, then wrap back to digit 0.
    runSlot("t1 d0", 1'b1, 16'h1234, X4, 4'b1110, 2'd0);
    runSlot("t1 d1", 1'b0, 16'h1234, X3, 4'b1101, 2'd1);
    runSlot("t1 d2", 1'b0, 16'h1234, X2, 4'b1011, 2'd2);
    runSlot("t1 d3", 1'b0, 16'h1234, X1, 4'b0111, 2'd3);
    applyStimulus(1'b1, 1'b0, 16'h1234);
    checkOutput("t1 wrap guard", XOFF, 4'b1111);
    applyStimulus(1'b1, 1'b0, 16'h1234);
    checkOutput("t1 wrap", X4, 4'b1110);
    applyStimulus(1'b1, 1'b0, 16'h1234);
    checkOutput("t1 wrap", X4, 4'b1110);

    // Load lands on the slot 0 -> 1 edge: that edge still shows old "4",
    // slot 1 then shows "7" from the new word, never "3".
    applyStimulus(1'b1, 1'b1, 16'h5678);
    checkOutput("t2 load edge", X4, 4'b1110);
    runSlot("t2 d1", 1'b0, 16'h5678, X7, 4'b1101, 2'd1);

    // Disable after one lit cycle of slot 2, then resume from held count.
    applyStimulus(1'b1, 1'b0, 16'h5678);
    checkOutput("t3 d2 guard", XOFF, 4'b1111);
    applyStimulus(1'b1, 1'b0, 16'h5678);
    checkOutput("t3 d2", X6, 4'b1011);
    checkIdx("t3 d2", 2'd2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h5678);
      checkOutput("t3 disabled", XOFF, 4'b1111);
      checkIdx("t3 disabled", 2'd2);
    end
    applyStimulus(1'b1, 1'b0, 16'h5678);
    checkOutput("t3 resume", X6, 4'b1011);
    applyStimulus(1'b1, 1'b0, 16'h5678);
    checkOutput("t3 resume", X6, 4'b1011);
    applyStimulus(1'b1, 1'b0, 16'h5678);
    checkOutput("t3 d3 guard", XOFF, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h5678);
      checkOutput("t3 d3", X5, 4'b0111);
    end

    // Non-BCD nibbles show a dash; upper zeros depend on suppression.
    runSlot("t4 d0", 1'b1, 16'h00AF, XDSH, 4'b1110, 2'd0);
    runSlot("t4 d1", 1'b0, 16'h00AF, XDSH, 4'b1101, 2'd1);
    runSlot("t4 d2", 1'b0, 16'h00AF, XLZ,  4'b1011, 2'd2);
    runSlot("t4 d3", 1'b0, 16'h00AF, XLZ,  4'b0111, 2'd3);

    // All-zero word: digit 0 always lit; then 0100 keeps the inner zero.
    runSlot("t5 d0", 1'b1, 16'h0000, X0,  4'b1110, 2'd0);
    runSlot("t5 d1", 1'b0, 16'h0000, XLZ, 4'b1101, 2'd1);
    runSlot("t5 d2", 1'b0, 16'h0000, XLZ, 4'b1011, 2'd2);
    runSlot("t5 d3", 1'b0, 16'h0000, XLZ, 4'b0111, 2'd3);
    runSlot("t5b d0", 1'b1, 16'h0100, X0,  4'b1110, 2'd0);
    runSlot("t5b d1", 1'b0, 16'h0100, X0,  4'b1101, 2'd1);
    runSlot("t5b d2", 1'b0, 16'h0100, X1,  4'b1011, 2'd2);
    runSlot("t5b d3", 1'b0, 16'h0100, XLZ, 4'b0111, 2'd3);

    // Reset in slot 3 alongside a load of 9999: reset wins everywhere.
    runSlot("t6 d0", 1'b0, 16'h0100, X0, 4'b1110, 2'd0);
    runSlot("t6 d1", 1'b0, 16'h0100, X0, 4'b1101, 2'd1);
    runSlot("t6 d2", 1'b0, 16'h0100, X1, 4'b1011, 2'd2);
    applyStimulus(1'b1, 1'b0, 16'h0100);
    checkOutput("t6 d3 guard", XOFF, 4'b1111);
    applyStimulus(1'b1, 1'b0, 16'h0100);
    checkOutput("t6 d3", XLZ, 4'b0111);
    checkIdx("t6 d3", 2'd3);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'h9999);
    checkOutput("t6 reset", XOFF, 4'b1111);
    checkIdx("t6 reset", 2'd0);
    reset = 1'b0;
    runSlot("t6 after reset", 1'b0, 16'h9999, X0, 4'b1110, 2'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
